// File: rtl/wptr_full.sv
// FIFO write-side pointer, full/almost-full flags and occupancy.
// Optional overflow detection: define WPTR_OVF_DET_EN.
module wptr_full #(
  parameter int ADDRSIZE    = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AFULL_L = PW'(AFULL_LEVEL);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] full_cmp;
  logic [ADDRSIZE:0] level_next;
  logic              wpush;
  logic              wfull_next;
  logic              wafull_next;

  // A write is accepted only while not full.
  assign wpush = winc & ~wfull;

  // Next binary and Gray write pointer.
  always_comb begin
    wbinnext  = wbin + PW'(wpush);
    wgraynext = (wbinnext >> 1) ^ wbinnext;
  end

  // Gray-to-binary of the synchronized read pointer.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  // Full when pointers differ only in the two MSBs (Gray form).
  always_comb begin
    full_cmp    = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                   wq2_rptr[ADDRSIZE-2:0]};
    wfull_next  = (wgraynext == full_cmp);
    level_next  = wbinnext - rbin_s;
    wafull_next = (level_next >= AFULL_L);
  end

  assign waddr = wbin[ADDRSIZE-1:0];

  // Pointer, flag and level registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= wfull_next;
      walmost_full <= wafull_next;
      wlevel       <= level_next;
    end
  end

`ifdef WPTR_OVF_DET_EN
  logic ovf_q;

  // Sticky overflow; a set wins over a same-cycle clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      ovf_q <= 1'b0;
    end else if (winc && wfull) begin
      ovf_q <= 1'b1;
    end else if (wovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign wovf = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = wovf_clr;
  assign wovf           = 1'b0;
`endif

endmodule
